// File: rtl/spike_rate_decoder.sv
// Spike-train readout: counts spikes over a programmable window and reports the
// spike count plus the index of the first spike through a valid/ready handshake.
module spike_rate_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spike,
    input  logic             en,
    input  logic [CNT_W-1:0] window_len,
    output logic [CNT_W-1:0] rate,
    output logic [CNT_W-1:0] first_lat,
    output logic             valid,
    input  logic             ready,
    output logic             missed,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONES = '1;
    localparam logic [CNT_W-1:0] ZERO = '0;
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] len_reg, len_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] lat_reg, lat_next;
    logic [CNT_W-1:0] idx_reg, idx_next;
    logic             seen_reg, seen_next;
    logic [CNT_W-1:0] rate_reg, rate_next;
    logic [CNT_W-1:0] first_lat_reg, first_lat_next;
    logic             valid_reg, valid_next;
    logic             missed_reg, missed_next;

    // Values including the spike sampled this cycle, so the final index is
    // folded into the registered result on the same edge.
    logic [CNT_W-1:0] cnt_upd;
    logic [CNT_W-1:0] lat_upd;
    logic             seen_upd;
    logic [CNT_W-1:0] len_m1;
    logic             last_idx;
    logic             start;

    // A length of 0 maps to a full 2^CNT_W window because len-1 wraps to all-ones.
    assign len_m1   = len_reg - ONE;
    assign last_idx = (idx_reg == len_m1);

    always_comb begin
        cnt_upd  = cnt_reg;
        lat_upd  = lat_reg;
        seen_upd = seen_reg;
        if (spike) begin
            if (cnt_reg != ONES) begin
                cnt_upd = cnt_reg + ONE;
            end
            if (!seen_reg) begin
                lat_upd  = idx_reg;
                seen_upd = 1'b1;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        cnt_next       = cnt_reg;
        lat_next       = lat_reg;
        idx_next       = idx_reg;
        seen_next      = seen_reg;
        rate_next      = rate_reg;
        first_lat_next = first_lat_reg;
        valid_next     = valid_reg;
        missed_next    = missed_reg;
        start          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (en) begin
                    start = 1'b1;
                end
            end
            COUNT: begin
                if (!en) begin
                    state_next = IDLE;
                end else begin
                    cnt_next  = cnt_upd;
                    lat_next  = lat_upd;
                    seen_next = seen_upd;
                    idx_next  = idx_reg + ONE;
                    if (last_idx) begin
                        rate_next      = cnt_upd;
                        first_lat_next = seen_upd ? lat_upd : ONES;
                        valid_next     = 1'b1;
                        state_next     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (spike) begin
                    missed_next = 1'b1;
                end
                if (valid_reg && ready) begin
                    valid_next = 1'b0;
                    if (en) begin
                        start = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A new window both from IDLE and straight out of a completed handshake.
        if (start) begin
            len_next   = window_len;
            cnt_next   = ZERO;
            lat_next   = ZERO;
            idx_next   = ZERO;
            seen_next  = 1'b0;
            state_next = COUNT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            len_reg       <= ZERO;
            cnt_reg       <= ZERO;
            lat_reg       <= ZERO;
            idx_reg       <= ZERO;
            seen_reg      <= 1'b0;
            rate_reg      <= ZERO;
            first_lat_reg <= ZERO;
            valid_reg     <= 1'b0;
            missed_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            cnt_reg       <= cnt_next;
            lat_reg       <= lat_next;
            idx_reg       <= idx_next;
            seen_reg      <= seen_next;
            rate_reg      <= rate_next;
            first_lat_reg <= first_lat_next;
            valid_reg     <= valid_next;
            missed_reg    <= missed_next;
        end
    end

    assign rate      = rate_reg;
    assign first_lat = first_lat_reg;
    assign valid     = valid_reg;
    assign missed    = missed_reg;
    assign busy      = (state_reg == COUNT);

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: table vectors, randomized windows
// against a window-level reference model, and hand sequences for corner cases.
module tb_spike_rate_decoder;

    logic       clk;
    logic       rst;
    logic       spike;
    logic       en;
    logic [7:0] window_len;
    logic [7:0] rate;
    logic [7:0] first_lat;
    logic       valid;
    logic       ready;
    logic       missed;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;

    spike_rate_decoder #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .spike      (spike),
        .en         (en),
        .window_len (window_len),
        .rate       (rate),
        .first_lat  (first_lat),
        .valid      (valid),
        .ready      (ready),
        .missed     (missed),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          len;
        logic [15:0] mask;
        int          exp_rate;
        int          exp_lat;
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: rate = spike count capped at 255, lat = first spike index or 255.
    function automatic void model(input int len, input logic [255:0] pat,
                                  output int er, output int el);
        int n;
        n  = (len == 0) ? 256 : len;
        er = 0;
        el = 255;
        for (int i = n - 1; i >= 0; i--) begin
            if (pat[i]) begin
                er = er + 1;
                el = i;
            end
        end
        if (er > 255) er = 255;
    endfunction

    // Runs one window from IDLE with ready high; en drops after the result so
    // the handshake returns the DUT to IDLE.
    task automatic do_window(input string nm, input int len, input logic [255:0] pat,
                             input int er, input int el);
        int   n;
        logic early;
        n          = (len == 0) ? 256 : len;
        window_len = 8'(len);
        en         = 1'b1;
        ready      = 1'b1;
        spike      = 1'b0;
        tick();
        chk({nm, " busy_at_start"}, int'(busy), 1);
        early = 1'b0;
        for (int i = 0; i < n; i++) begin
            spike      = pat[i];
            window_len = 8'($urandom);
            tick();
            if (i < n - 1 && valid) early = 1'b1;
        end
        spike = 1'b0;
        en    = 1'b0;
        chk({nm, " early_valid"}, int'(early), 0);
        chk({nm, " valid"}, int'(valid), 1);
        chk({nm, " rate"}, int'(rate), er);
        chk({nm, " first_lat"}, int'(first_lat), el);
        $display("window %s len=%0d rate=%0d first_lat=%0d exp=%0d/%0d",
                 nm, len, rate, first_lat, er, el);
        tick();
        chk({nm, " valid_pulse_end"}, int'(valid), 0);
        chk({nm, " idle_after"}, int'(busy), 0);
    endtask

    initial begin
        logic [255:0] pat;
        int           er, el, len, prev_rate;
        logic         stable, vseen;

        tbl[0] = '{10, 16'h0218, 3, 3};
        tbl[1] = '{5,  16'h0000, 0, 255};
        tbl[2] = '{1,  16'h0001, 1, 0};
        tbl[3] = '{8,  16'h0080, 1, 7};
        tbl[4] = '{16, 16'hFFFF, 16, 0};
        tbl[5] = '{12, 16'h0A50, 4, 4};

        rst = 1'b1; spike = 1'b0; en = 1'b0; ready = 1'b0; window_len = 8'd0;
        #3;
        chk("reset rate", int'(rate), 0);
        chk("reset first_lat", int'(first_lat), 0);
        chk("reset valid", int'(valid), 0);
        chk("reset missed", int'(missed), 0);
        chk("reset busy", int'(busy), 0);
        tick();
        rst = 1'b0;
        tick();

        for (int t = 0; t < 6; t++) begin
            pat = '0;
            pat[15:0] = tbl[t].mask;
            do_window($sformatf("tbl%0d", t), tbl[t].len, pat, tbl[t].exp_rate, tbl[t].exp_lat);
        end

        do_window("saturate", 0, {256{1'b1}}, 255, 0);
        pat = '0;
        pat[255] = 1'b1;
        do_window("last_index", 0, pat, 1, 255);

        for (int r = 0; r < 12; r++) begin
            len = int'($urandom_range(1, 40));
            pat = '0;
            for (int i = 0; i < 40; i++) pat[i] = ($urandom_range(0, 3) == 0);
            if (r == 3) pat = '0;
            model(len, pat, er, el);
            do_window($sformatf("rand%0d", r), len, pat, er, el);
        end

        // Backpressure: result held while ready is low, HOLD spike flags missed.
        chk("bp missed_before", int'(missed), 0);
        window_len = 8'd4; en = 1'b1; ready = 1'b0; spike = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            spike = (i == 1);
            tick();
        end
        spike = 1'b0;
        chk("bp valid", int'(valid), 1);
        chk("bp rate", int'(rate), 1);
        chk("bp first_lat", int'(first_lat), 1);
        stable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            spike = (i == 1);
            tick();
            if (!valid || rate != 8'd1 || first_lat != 8'd1) stable = 1'b0;
        end
        spike = 1'b0;
        chk("bp stable", int'(stable), 1);
        chk("bp missed", int'(missed), 1);
        ready = 1'b1; window_len = 8'd3;
        tick();
        chk("bp handshake valid", int'(valid), 0);
        chk("bp next_window busy", int'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            spike = (i == 2);
            tick();
        end
        spike = 1'b0; en = 1'b0;
        chk("b2b valid", int'(valid), 1);
        chk("b2b rate", int'(rate), 1);
        chk("b2b first_lat", int'(first_lat), 2);
        $display("window backpressure+b2b rate=%0d first_lat=%0d missed=%0d", rate, first_lat, missed);
        tick();
        chk("b2b idle", int'(busy), 0);

        // Abort at index 2: no result, previous rate retained.
        prev_rate  = int'(rate);
        window_len = 8'd8; en = 1'b1; ready = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            spike = 1'b1;
            tick();
        end
        spike = 1'b0; en = 1'b0;
        tick();
        chk("abort idle", int'(busy), 0);
        vseen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid) vseen = 1'b1;
        end
        chk("abort no_valid", int'(vseen), 0);
        chk("abort rate_kept", int'(rate), prev_rate);
        $display("window abort rate=%0d valid_seen=%0d", rate, vseen);

        // Asynchronous reset at index 5 with 4 spikes seen.
        window_len = 8'd10; en = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            spike = (i < 4);
            tick();
        end
        spike = 1'b0; en = 1'b0;
        chk("rst pre_missed", int'(missed), 1);
        chk("rst pre_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("rst async rate", int'(rate), 0);
        chk("rst async first_lat", int'(first_lat), 0);
        chk("rst async valid", int'(valid), 0);
        chk("rst async missed", int'(missed), 0);
        chk("rst async busy", int'(busy), 0);
        $display("reset mid-window rate=%0d busy=%0d missed=%0d", rate, busy, missed);
        rst = 1'b0;
        tick();
        pat = '0;
        pat[15:0] = 16'h0218;
        do_window("post_reset", 10, pat, 3, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
